// File: rtl/calc2_port_responder.sv
// calc2_port_responder
// Two-cycle request capture (command + operand1, then operand2), a small
// arithmetic/shift unit, a response FIFO and a held output register.
//
// Ports:
//   c_clk        single clock, all state changes on its rising edge
//   reset        asynchronous, active-low reset
//   req_cmd_in   command: 0 none, 1 add, 2 sub, 5 shl, 6 shr, others invalid
//   req_data_in  operand1 in the command cycle, operand2 in the next cycle
//   req_tag_in   tag sampled together with the command
//   out_resp     0 none, 1 success, 2 overflow/underflow/invalid
//   out_data     result of the presented response
//   out_tag      tag of the presented response
//   out_ack      consumer accepts the presented response
//   q_count      results queued but not yet presented
//   drop_cnt     saturating count of results lost to a full queue
//
// QDEPTH must be a power of two, at least 2. DATA_W must be at least 5
// because shift amounts come from operand2[4:0].

module calc2_port_responder #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 2,
   parameter int QDEPTH = 4
) (
   input  logic                      c_clk,
   input  logic                      reset,
   input  logic [3:0]                req_cmd_in,
   input  logic [DATA_W-1:0]         req_data_in,
   input  logic [TAG_W-1:0]          req_tag_in,
   output logic [1:0]                out_resp,
   output logic [DATA_W-1:0]         out_data,
   output logic [TAG_W-1:0]          out_tag,
   input  logic                      out_ack,
   output logic [$clog2(QDEPTH):0]   q_count,
   output logic [7:0]                drop_cnt
);

   localparam int PW      = $clog2(QDEPTH);
   localparam int ENTRY_W = 2 + DATA_W + TAG_W;

   localparam logic [3:0] CMD_NONE = 4'd0;
   localparam logic [3:0] CMD_ADD  = 4'd1;
   localparam logic [3:0] CMD_SUB  = 4'd2;
   localparam logic [3:0] CMD_SHL  = 4'd5;
   localparam logic [3:0] CMD_SHR  = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   localparam logic [PW:0]   FULL_CNT = (PW+1)'(QDEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   typedef enum logic {IDLE, OP2} state_t;

   state_t              state;
   state_t              state_next;

   logic [3:0]          cmd_q;
   logic [DATA_W-1:0]   op1_q;
   logic [TAG_W-1:0]    tag_q;
   logic                capture;

   logic [DATA_W:0]     sum;
   logic [1:0]          res_resp;
   logic [DATA_W-1:0]   res_data;

   logic [ENTRY_W-1:0]  mem [QDEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [PW:0]         count;
   logic [PW:0]         count_next;
   logic                full;
   logic                push_try;
   logic                push_ok;
   logic                pop;
   logic                drop;

   logic [1:0]          head_resp;
   logic [DATA_W-1:0]   head_data;
   logic [TAG_W-1:0]    head_tag;

   assign capture  = (state == IDLE) && (req_cmd_in != CMD_NONE);
   assign push_try = (state == OP2);
   assign full     = (count == FULL_CNT);

   // The output register takes a new head whenever it is empty or its
   // current response is being acknowledged this edge.
   assign pop     = (count != '0) && ((out_resp == RESP_NONE) || out_ack);
   // A full queue still accepts when a slot is freed at the same edge.
   assign push_ok = push_try && (!full || pop);
   assign drop    = push_try && full && !pop;

   assign {head_resp, head_data, head_tag} = mem[rd_ptr];
   assign q_count = count;

   // Capture FSM: IDLE waits for a command, OP2 lasts exactly one cycle
   // while operand2 is on the data bus; commands seen in OP2 are ignored.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (req_cmd_in != CMD_NONE) state_next = OP2;
         OP2:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Command, operand1 and tag are held from the command edge until the
   // operand2 edge, where they are combined with the live data bus.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         cmd_q <= CMD_NONE;
         op1_q <= '0;
         tag_q <= '0;
      end else if (capture) begin
         cmd_q <= req_cmd_in;
         op1_q <= req_data_in;
         tag_q <= req_tag_in;
      end
   end

   // Execute unit: operand2 is taken directly from the bus during OP2.
   // Every error result carries data 0.
   always_comb begin
      res_resp = RESP_ERR;
      res_data = '0;
      sum      = {1'b0, op1_q} + {1'b0, req_data_in};
      case (cmd_q)
         CMD_ADD: begin
            if (!sum[DATA_W]) begin
               res_resp = RESP_OK;
               res_data = sum[DATA_W-1:0];
            end
         end
         CMD_SUB: begin
            if (req_data_in <= op1_q) begin
               res_resp = RESP_OK;
               res_data = op1_q - req_data_in;
            end
         end
         CMD_SHL: begin
            res_resp = RESP_OK;
            res_data = op1_q << req_data_in[4:0];
         end
         CMD_SHR: begin
            res_resp = RESP_OK;
            res_data = op1_q >> req_data_in[4:0];
         end
         default: begin
            res_resp = RESP_ERR;
            res_data = '0;
         end
      endcase
   end

   // Queue storage carries no reset; emptiness is tracked by count alone.
   always_ff @(posedge c_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= {res_resp, res_data, tag_q};
      end
   end

   always_comb begin
      count_next = count;
      if (push_ok && !pop) begin
         count_next = count + CNT_ONE;
      end else if (!push_ok && pop) begin
         count_next = count - CNT_ONE;
      end
   end

   // Pointers wrap naturally because QDEPTH is a power of two.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_next;
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         drop_cnt <= 8'd0;
      end else if (drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // Output register: holds a response until acknowledged, then takes the
   // next head or clears; an ack with nothing presented does nothing.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         out_resp <= RESP_NONE;
         out_data <= '0;
         out_tag  <= '0;
      end else if (pop) begin
         out_resp <= head_resp;
         out_data <= head_data;
         out_tag  <= head_tag;
      end else if (out_ack && (out_resp != RESP_NONE)) begin
         out_resp <= RESP_NONE;
         out_data <= '0;
         out_tag  <= '0;
      end
   end

endmodule
